// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two requesters.
// Ports: p0_*/p1_* requester command/grant/read-data, ctrl_* controller side, busy/owner status.
module sram_arbiter #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 p0_req,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic                 p0_write_enable,
  input  logic [DATA_BITS-1:0] p0_write_data,
  output logic                 p0_grant,
  output logic [DATA_BITS-1:0] p0_read_data,
  output logic                 p0_read_data_valid,
  input  logic                 p1_req,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic                 p1_write_enable,
  input  logic [DATA_BITS-1:0] p1_write_data,
  output logic                 p1_grant,
  output logic [DATA_BITS-1:0] p1_read_data,
  output logic                 p1_read_data_valid,
  output logic                 ctrl_req,
  input  logic                 ctrl_ready,
  output logic [ADDR_BITS-1:0] ctrl_addr,
  output logic                 ctrl_write_enable,
  output logic [DATA_BITS-1:0] ctrl_write_data,
  input  logic [DATA_BITS-1:0] ctrl_read_data,
  input  logic                 ctrl_read_data_valid,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t state_q, state_d;

  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 got_q, got_d;
  logic [DATA_BITS-1:0] rd0_q, rd0_d;
  logic [DATA_BITS-1:0] rd1_q, rd1_d;
  logic                 rv0_q, rv0_d;
  logic                 rv1_q, rv1_d;

  logic any_req;
  logic win;
  logic rd_hit;

  assign any_req = p0_req | p1_req;

  // On a tie the port that did not win last time goes next.
  assign win = (p0_req & p1_req) ? ~last_q : p1_req;

  // Read data only counts while a read is outstanding.
  assign rd_hit = (state_q == S_BUSY) & ctrl_read_data_valid & ~we_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    got_d   = got_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_ready && any_req) begin
          state_d = S_ISSUE;
          owner_d = win;
          last_d  = win;
          addr_d  = win ? p1_addr : p0_addr;
          we_d    = win ? p1_write_enable : p0_write_enable;
          wdata_d = win ? p1_write_data : p0_write_data;
        end
      end
      S_ISSUE: begin
        state_d = S_BUSY;
        got_d   = 1'b0;
      end
      S_BUSY: begin
        if (rd_hit) begin
          got_d = 1'b1;
          if (owner_q) begin
            rd1_d = ctrl_read_data;
            rv1_d = 1'b1;
          end else begin
            rd0_d = ctrl_read_data;
            rv0_d = 1'b1;
          end
        end
        // Data may arrive in the same cycle ready returns.
        if (ctrl_ready && (we_q || got_q || rd_hit)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      got_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      got_q   <= got_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign ctrl_req           = (state_q == S_ISSUE);
  assign p0_grant           = ctrl_req & ~owner_q;
  assign p1_grant           = ctrl_req & owner_q;
  assign ctrl_addr          = addr_q;
  assign ctrl_write_enable  = we_q;
  assign ctrl_write_data    = wdata_q;
  assign p0_read_data       = rd0_q;
  assign p1_read_data       = rd1_q;
  assign p0_read_data_valid = rv0_q;
  assign p1_read_data_valid = rv1_q;
  assign busy               = (state_q != S_IDLE);
  assign owner              = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a 3-cycle behavioural controller.
// Stimulus pushes expected grants/reads; a negedge monitor pops and compares.
module tb_sram_arbiter;

  typedef struct {
    logic [19:0] a;
    logic        we;
    logic [15:0] wd;
  } gexp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [19:0] p0_addr = '0, p1_addr = '0;
  logic        p0_write_enable = 1'b0, p1_write_enable = 1'b0;
  logic [15:0] p0_write_data = '0, p1_write_data = '0;
  logic        p0_grant, p1_grant;
  logic [15:0] p0_read_data, p1_read_data;
  logic        p0_read_data_valid, p1_read_data_valid;
  logic        ctrl_req, ctrl_ready;
  logic [19:0] ctrl_addr;
  logic        ctrl_write_enable;
  logic [15:0] ctrl_write_data;
  logic [15:0] ctrl_read_data = '0;
  logic        ctrl_read_data_valid = 1'b0;
  logic        busy, owner;

  int pass_cnt = 0;
  int total_cnt = 0;

  gexp_t       gq0[$], gq1[$];
  logic [15:0] rq0[$], rq1[$];
  bit          seen[$];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr),
    .p0_write_enable(p0_write_enable), .p0_write_data(p0_write_data),
    .p0_grant(p0_grant), .p0_read_data(p0_read_data),
    .p0_read_data_valid(p0_read_data_valid),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p1_write_enable(p1_write_enable), .p1_write_data(p1_write_data),
    .p1_grant(p1_grant), .p1_read_data(p1_read_data),
    .p1_read_data_valid(p1_read_data_valid),
    .ctrl_req(ctrl_req), .ctrl_ready(ctrl_ready),
    .ctrl_addr(ctrl_addr), .ctrl_write_enable(ctrl_write_enable),
    .ctrl_write_data(ctrl_write_data), .ctrl_read_data(ctrl_read_data),
    .ctrl_read_data_valid(ctrl_read_data_valid),
    .busy(busy), .owner(owner)
  );

  function automatic logic [15:0] pat(input logic [19:0] a);
    return (a == 20'h3) ? 16'h1234 : (a[15:0] ^ 16'hC3C3);
  endfunction

  // Controller model: accepts when ready, completes 3 edges later.
  logic        m_ready = 1'b1;
  logic        hold_low = 1'b0;
  int          m_cnt = 0;
  logic        m_we = 1'b0;
  logic [19:0] m_addr = '0;

  assign ctrl_ready = m_ready & ~hold_low;

  always @(posedge clk) begin
    ctrl_read_data_valid <= 1'b0;
    if (ctrl_req && ctrl_ready) begin
      m_ready <= 1'b0;
      m_cnt   <= 3;
      m_we    <= ctrl_write_enable;
      m_addr  <= ctrl_addr;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        if (!m_we) begin
          ctrl_read_data_valid <= 1'b1;
          ctrl_read_data       <= pat(m_addr);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    total_cnt++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic chk_grant(input bit p);
    gexp_t e;
    if (p ? gq1.size() == 0 : gq0.size() == 0) begin
      fail(p ? "unexpected_grant_p1" : "unexpected_grant_p0");
      return;
    end
    e = p ? gq1.pop_front() : gq0.pop_front();
    seen.push_back(p);
    check("grant_ctrl_req", 32'(ctrl_req), 32'(1));
    check("grant_owner", 32'(owner), 32'(p));
    check("grant_addr", 32'(ctrl_addr), 32'(e.a));
    check("grant_we", 32'(ctrl_write_enable), 32'(e.we));
    if (e.we) check("grant_wdata", 32'(ctrl_write_data), 32'(e.wd));
  endtask

  task automatic chk_rd(input bit p);
    logic [15:0] d;
    if (p ? rq1.size() == 0 : rq0.size() == 0) begin
      fail(p ? "unexpected_rdv_p1" : "unexpected_rdv_p0");
      return;
    end
    d = p ? rq1.pop_front() : rq0.pop_front();
    if (p) check("rdata_p1", 32'(p1_read_data), 32'(d));
    else   check("rdata_p0", 32'(p0_read_data), 32'(d));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (p0_grant && p1_grant) fail("dual_grant");
      if (p0_grant) chk_grant(1'b0);
      if (p1_grant) chk_grant(1'b1);
      if (p0_read_data_valid) chk_rd(1'b0);
      if (p1_read_data_valid) chk_rd(1'b1);
    end
  end

  task automatic push(input bit p, input logic [19:0] a, input logic we,
                      input logic [15:0] wd, input bit exp_rd);
    gexp_t e;
    e.a = a; e.we = we; e.wd = wd;
    if (p) gq1.push_back(e); else gq0.push_back(e);
    if (exp_rd && !we) begin
      if (p) rq1.push_back(pat(a)); else rq0.push_back(pat(a));
    end
  endtask

  task automatic op(input bit p, input logic [19:0] a, input logic we,
                    input logic [15:0] wd, input bit exp_rd);
    bit got = 0;
    push(p, a, we, wd, exp_rd);
    if (p) begin
      p1_addr = a; p1_write_enable = we; p1_write_data = wd; p1_req = 1'b1;
    end else begin
      p0_addr = a; p0_write_enable = we; p0_write_data = wd; p0_req = 1'b1;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = p ? p1_grant : p0_grant;
    end
    if (!got) fail("grant_timeout");
    if (p) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !busy && ctrl_ready && rq0.size() == 0 && rq1.size() == 0
           && gq0.size() == 0 && gq1.size() == 0;
    end
    if (!ok) fail("idle_timeout");
  endtask

  initial begin
    int n;
    int gc;
    // Reset with both ports requesting.
    p0_addr = 20'h00100; p0_req = 1'b1;
    p1_addr = 20'h00200; p1_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({p0_grant, p1_grant, ctrl_req, ctrl_write_enable, busy, owner,
               p0_read_data_valid, p1_read_data_valid}), 32'(0));
    check("reset_ctrl_addr", 32'(ctrl_addr), 32'(0));
    check("reset_wdata", 32'(ctrl_write_data), 32'(0));
    check("reset_rdata", 32'({p0_read_data, p1_read_data}), 32'(0));
    push(1'b0, 20'h00100, 1'b0, 16'h0, 1'b1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_grant_p0", 32'(p0_grant), 32'(1));
    check("first_owner", 32'(owner), 32'(0));
    check("first_addr", 32'(ctrl_addr), 32'(20'h00100));
    p0_req = 1'b0;
    op(1'b1, 20'h00200, 1'b0, 16'h0, 1'b1);
    wait_idle();

    // Single write from port 1.
    op(1'b1, 20'h00012, 1'b1, 16'hA5A5, 1'b0);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      n++;
    end
    check("write_busy_cycles", 32'(n), 32'(5));
    wait_idle();

    // Alternation with both ports always requesting.
    seen.delete();
    fork
      for (int i = 0; i < 4; i++) op(1'b0, 20'h10 + 20'(i), 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 4; i++) op(1'b1, 20'h20 + 20'(i), 1'b0, 16'h0, 1'b1);
    join
    wait_idle();
    check("alt_count", 32'(seen.size()), 32'(8));
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("alt_order", 32'(seen[i]), 32'(i % 2));

    // Read routing to port 0 only.
    op(1'b0, 20'h3, 1'b0, 16'h0, 1'b1);
    wait_idle();
    check("route_p0_data", 32'(p0_read_data), 32'(16'h1234));
    check("route_p1_hold", 32'(p1_read_data), 32'(pat(20'h23)));

    // Controller not ready in IDLE.
    hold_low = 1'b1;
    push(1'b1, 20'h00055, 1'b1, 16'h0F0F, 1'b0);
    p1_addr = 20'h00055; p1_write_enable = 1'b1; p1_write_data = 16'h0F0F;
    p1_req = 1'b1;
    gc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (p0_grant || p1_grant) gc++;
    end
    check("ready_low_no_grant", 32'(gc), 32'(0));
    hold_low = 1'b0;
    @(posedge clk); #1;
    check("ready_high_grant_p1", 32'(p1_grant), 32'(1));
    p1_req = 1'b0;
    wait_idle();

    // Reset in the middle of a port 0 read.
    op(1'b0, 20'h00040, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_p0_data", 32'(p0_read_data), 32'(0));
    #1;
    reset_n = 1'b1;
    seen.delete();
    fork
      op(1'b0, 20'h00060, 1'b0, 16'h0, 1'b1);
      op(1'b1, 20'h00070, 1'b0, 16'h0, 1'b1);
    join
    wait_idle();
    check("midrst_tie_count", 32'(seen.size()), 32'(2));
    if (seen.size() > 0) check("midrst_tie_p0", 32'(seen[0]), 32'(0));
    else fail("midrst_tie_p0");
    check("final_p0_data", 32'(p0_read_data), 32'(pat(20'h60)));
    check("final_p1_data", 32'(p1_read_data), 32'(pat(20'h70)));
    check("queues_empty",
          32'(gq0.size() + gq1.size() + rq0.size() + rq1.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
